// File: rtl/alu_uart_pkg.sv
// Shared types and constants for the UART-attached ALU host: sequencing states,
// receiver states, ALU opcodes and 8N1 framing levels.
package alu_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        SEND_OP,
        WAIT_RES,
        DONE
    } host_state_t;

    typedef enum logic [2:0] {
        RX_WAIT_HIGH,
        RX_HUNT,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_SUB = 8'h22;
    localparam logic [7:0] OP_AND = 8'h24;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_XOR = 8'h26;
    localparam logic [7:0] OP_SRA = 8'h03;
    localparam logic [7:0] OP_SRL = 8'h02;
    localparam logic [7:0] OP_NOR = 8'h27;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/alu_uart_host_rx_sampler.sv
// host_rx_sampler: 2-FF sync of the result line, start detect with mid-bit re-check,
// 16x-tick data sampling and stop check. start_det_o exists only with ALU_HOST_TIMEOUT_EN.
module host_rx_sampler
    import alu_uart_pkg::*;
#(
    parameter int N_BITS  = 8,
    parameter int N_TICKS = 16
) (
    input  logic              clock_i,
    input  logic              rst_n_i,
    input  logic              tick_i,
    input  logic              arm_i,
    input  logic              rx_i,
`ifdef ALU_HOST_TIMEOUT_EN
    output logic              start_det_o,
`endif
    output logic              valid_o,
    output logic [N_BITS-1:0] data_o,
    output logic              frame_err_o
);

    localparam int TW = $clog2(N_TICKS);
    localparam int BW = $clog2(N_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(N_TICKS - 1);
    // Seen on the 7th tick after detection: roughly the middle of the start bit.
    localparam logic [TW-1:0] MID_LAST  = TW'(N_TICKS / 2 - 2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(N_BITS - 1);

    logic              rx_meta_q, rx_sync_q;
    rx_state_t         rs_q, rs_d;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [N_BITS-1:0] shift_q, shift_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;

    always_ff @(posedge clock_i) begin
        if (!rst_n_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rs_q      <= RX_WAIT_HIGH;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rs_q      <= rs_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    // After a bad stop (line possibly held low) wait for idle before hunting again.
    always_comb begin
        rs_d    = rs_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        if (!arm_i) begin
            rs_d = RX_WAIT_HIGH;
        end else if (tick_i) begin
            case (rs_q)
                RX_WAIT_HIGH: if (rx_sync_q) rs_d = RX_HUNT;
                RX_HUNT: begin
                    if (!rx_sync_q) begin
                        rs_d  = RX_START;
                        cnt_d = '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == MID_LAST) begin
                        cnt_d = '0;
                        bit_d = '0;
                        rs_d  = rx_sync_q ? RX_HUNT : RX_DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == TICK_LAST) begin
                        cnt_d   = '0;
                        shift_d = {rx_sync_q, shift_q[N_BITS-1:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) rs_d = RX_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == TICK_LAST) begin
                        cnt_d = '0;
                        if (rx_sync_q == STOP_BIT) begin
                            valid_d = 1'b1;
                            rs_d    = RX_HUNT;
                        end else begin
                            ferr_d = 1'b1;
                            rs_d   = RX_WAIT_HIGH;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: rs_d = RX_WAIT_HIGH;
            endcase
        end
    end

`ifdef ALU_HOST_TIMEOUT_EN
    assign start_det_o = arm_i && tick_i && (rs_q == RX_HUNT) && !rx_sync_q;
`endif
    assign valid_o     = valid_q;
    assign data_o      = shift_q;
    assign frame_err_o = ferr_q;

endmodule

// File: rtl/alu_uart_host.sv
// Host-side UART initiator: sends A, B, opcode as 8N1 frames, then waits for the result frame.
// Define ALU_HOST_TIMEOUT_EN to build the WAIT_RES tick timeout and drive o_timeout.
module alu_uart_host
    import alu_uart_pkg::*;
#(
    parameter int LIMITE        = 163,
    parameter int NB_CONTA      = 8,
    parameter int N_BITS        = 8,
    parameter int N_TICKS       = 16,
    parameter int TIMEOUT_TICKS = 640
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [N_BITS-1:0] i_op_a,
    input  logic [N_BITS-1:0] i_op_b,
    input  logic [N_BITS-1:0] i_opcode,
    input  logic              i_rx,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_done,
    output logic [N_BITS-1:0] o_result,
    output logic              o_timeout,
    output logic              o_frame_err
);

    localparam int TW  = $clog2(N_TICKS);
    localparam int FW  = N_BITS + 2;
    localparam int FBW = $clog2(FW);
    localparam logic [TW-1:0]  TICK_LAST  = TW'(N_TICKS - 1);
    localparam logic [FBW-1:0] FBIT_LAST  = FBW'(FW - 1);

    logic [NB_CONTA-1:0] baud_q;
    logic                tick;
    host_state_t         state_q, state_d;
    logic [N_BITS-1:0]   a_q, b_q, op_q, result_q;
    logic                tx_active_q;
    logic [FW-1:0]       tx_shift_q;
    logic [TW-1:0]       tx_tick_q;
    logic [FBW-1:0]      tx_bit_q;
    logic [N_BITS-1:0]   send_byte;
    logic                is_send, frame_done, armed;
    logic                rx_valid, rx_ferr, timeout_hit;
    logic [N_BITS-1:0]   rx_data;

    assign tick = (baud_q == NB_CONTA'(LIMITE - 1));

    always_ff @(posedge i_clock) begin
        if (!i_reset || tick) baud_q <= '0;
        else                  baud_q <= baud_q + 1'b1;
    end

    assign is_send    = (state_q == SEND_A) || (state_q == SEND_B) || (state_q == SEND_OP);
    assign armed      = (state_q == WAIT_RES);
    assign frame_done = tx_active_q && tick && (tx_tick_q == TICK_LAST) && (tx_bit_q == FBIT_LAST);

    always_comb begin
        case (state_q)
            SEND_A:  send_byte = a_q;
            SEND_B:  send_byte = b_q;
            default: send_byte = op_q;
        endcase
    end

    // The frame is loaded on the first cycle of each SEND state, so the start bit follows one cycle later.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            tx_active_q <= 1'b0;
            tx_shift_q  <= '1;
            tx_tick_q   <= '0;
            tx_bit_q    <= '0;
        end else if (!is_send) begin
            tx_active_q <= 1'b0;
        end else if (!tx_active_q) begin
            tx_active_q <= 1'b1;
            tx_shift_q  <= {STOP_BIT, send_byte, START_BIT};
            tx_tick_q   <= '0;
            tx_bit_q    <= '0;
        end else if (tick) begin
            if (tx_tick_q == TICK_LAST) begin
                tx_tick_q <= '0;
                if (tx_bit_q == FBIT_LAST) begin
                    tx_active_q <= 1'b0;
                end else begin
                    tx_shift_q <= {1'b1, tx_shift_q[FW-1:1]};
                    tx_bit_q   <= tx_bit_q + 1'b1;
                end
            end else begin
                tx_tick_q <= tx_tick_q + 1'b1;
            end
        end
    end

    assign o_tx = tx_active_q ? tx_shift_q[0] : STOP_BIT;

`ifdef ALU_HOST_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_TICKS + 1);
    logic [TOW-1:0] to_cnt_q;
    logic           rx_start_det;
    logic           timeout_q;

    always_ff @(posedge i_clock) begin
        if (!i_reset || !armed || rx_start_det) to_cnt_q <= '0;
        else if (tick)                          to_cnt_q <= to_cnt_q + 1'b1;
    end

    assign timeout_hit = armed && tick && !rx_start_det && (to_cnt_q == TOW'(TIMEOUT_TICKS - 1));

    always_ff @(posedge i_clock) begin
        if (!i_reset)                timeout_q <= 1'b0;
        else if (armed && rx_valid)  timeout_q <= 1'b0;
        else if (timeout_hit)        timeout_q <= 1'b1;
    end

    assign o_timeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign o_timeout   = 1'b0;
`endif

    host_rx_sampler #(
        .N_BITS (N_BITS),
        .N_TICKS(N_TICKS)
    ) u_rx (
        .clock_i    (i_clock),
        .rst_n_i    (i_reset),
        .tick_i     (tick),
        .arm_i      (armed),
        .rx_i       (i_rx),
`ifdef ALU_HOST_TIMEOUT_EN
        .start_det_o(rx_start_det),
`endif
        .valid_o    (rx_valid),
        .data_o     (rx_data),
        .frame_err_o(rx_ferr)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && i_start) begin
                a_q  <= i_op_a;
                b_q  <= i_op_b;
                op_q <= i_opcode;
            end
            if (armed && rx_valid)  result_q <= rx_data;
            else if (timeout_hit)   result_q <= '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (i_start)    state_d = SEND_A;
            SEND_A:   if (frame_done) state_d = SEND_B;
            SEND_B:   if (frame_done) state_d = SEND_OP;
            SEND_OP:  if (frame_done) state_d = WAIT_RES;
            WAIT_RES: if (rx_valid || timeout_hit) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    assign o_busy      = (state_q != IDLE);
    assign o_done      = (state_q == DONE);
    assign o_result    = result_q;
    assign o_frame_err = rx_ferr;

endmodule

// File: tb/tb_alu_uart_host.sv
// Scoreboard bench for alu_uart_host: decodes o_tx frames, replies on i_rx with an ALU model,
// checks results at o_done. The timeout scenario runs only when ALU_HOST_TIMEOUT_EN is defined.
module tb_alu_uart_host;
    import alu_uart_pkg::*;

    localparam int L     = 4;
    localparam int NT    = 16;
    localparam int TO    = 640;
    localparam int BIT   = L * NT;
    localparam int FRAME = BIT * 10;

    logic       clk = 1'b0;
    logic       rst_n, start, rx;
    logic [7:0] op_a, op_b, opcode;
    logic       tx, busy, done, timeout, ferr;
    logic [7:0] result;

    always #5 clk = ~clk;

    alu_uart_host #(
        .LIMITE(L), .NB_CONTA(8), .N_BITS(8), .N_TICKS(NT), .TIMEOUT_TICKS(TO)
    ) dut (
        .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_op_a(op_a), .i_op_b(op_b),
        .i_opcode(opcode), .i_rx(rx), .o_tx(tx), .o_busy(busy), .o_done(done),
        .o_result(result), .o_timeout(timeout), .o_frame_err(ferr)
    );

    int checks = 0, failures = 0;
    int cyc = 0, done_count = 0, ferr_count = 0, frames_seen = 0, done_cyc = 0, last_fall = 0;
    logic [7:0] exp_tx[$];
    logic [8:0] exp_res[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SRA:  return $unsigned($signed(a) >>> b);
            OP_SRL:  return a >> b;
            OP_NOR:  return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (ferr === 1'b1) ferr_count <= ferr_count + 1;

    task automatic mon_wait(input int n, inout bit ab);
        for (int k = 0; k < n && !ab; k++) begin
            @(negedge clk);
            if (rst_n !== 1'b1) ab = 1'b1;
        end
    endtask

    // o_tx frame decoder: samples mid-bit; frames cut by reset are discarded.
    logic [7:0] mon_d;
    logic       mon_stp;
    bit         mon_ab;
    int         mon_f;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                mon_ab = 1'b0;
                mon_f  = cyc;
                mon_wait(BIT / 2, mon_ab);
                for (int i = 0; i < 8; i++) begin
                    mon_wait(BIT, mon_ab);
                    mon_d[i] = tx;
                end
                mon_wait(BIT, mon_ab);
                mon_stp = tx;
                if (!mon_ab) begin
                    frames_seen++;
                    last_fall = mon_f;
                    check_eq("tx_stop_bit", 32'(mon_stp), 32'd1);
                    if (exp_tx.size() == 0) check_eq("tx_extra_frame_qsize", exp_tx.size(), 1);
                    else                    check_eq("tx_byte", 32'(mon_d), 32'(exp_tx.pop_front()));
                    $display("tx frame byte=0x%02h stop=%0d", mon_d, mon_stp);
                end
            end
        end
    end

    logic [8:0] mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_count++;
                done_cyc = cyc;
                if (exp_res.size() == 0) begin
                    check_eq("done_extra_qsize", exp_res.size(), 1);
                end else begin
                    mon_e = exp_res.pop_front();
                    check_eq("result", 32'(result), 32'(mon_e[7:0]));
                    check_eq("timeout", 32'(timeout), 32'(mon_e[8]));
                end
                $display("done result=0x%02h timeout=%0d", result, timeout);
                @(negedge clk);
                check_eq("done_one_cycle", 32'(done), 32'd0);
                check_eq("busy_after_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic send_rx(input logic [7:0] d, input logic stp);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stp;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        op_a = a; op_b = b; opcode = op; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_frames();
        for (int k = 0; k < 4 * FRAME && exp_tx.size() != 0; k++) @(negedge clk);
        check_eq("tx_frames_pending", exp_tx.size(), 0);
    endtask

    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input bit bad);
        logic [7:0] rep;
        int d0, f0, fr0;
        rep = alu_ref(a, b, op);
        d0 = done_count; f0 = ferr_count; fr0 = frames_seen;
        exp_tx.push_back(a); exp_tx.push_back(b); exp_tx.push_back(op);
        exp_res.push_back({1'b0, rep});
        pulse_start(a, b, op);
        check_eq("busy_after_start", 32'(busy), 32'd1);
        wait_frames();
        repeat (2 * BIT) @(negedge clk);
        if (bad) begin
            send_rx(rep, 1'b0);
            check_eq("frame_err_pulses", ferr_count - f0, 1);
        end
        send_rx(rep, 1'b1);
        for (int k = 0; k < 4 * FRAME && done_count == d0; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        check_eq("done_pulses", done_count - d0, 1);
        check_eq("frames_per_txn", frames_seen - fr0, 3);
        if (!bad) check_eq("no_frame_err", ferr_count - f0, 0);
        $display("txn a=0x%02h b=0x%02h op=0x%02h reply=0x%02h bad_first=%0d", a, b, op, rep, bad);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; opcode = '0; rx = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("rst_tx", 32'(tx), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_result", 32'(result), 32'd0);
        check_eq("rst_timeout", 32'(timeout), 32'd0);
        check_eq("rst_frame_err", 32'(ferr), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        run_txn(8'h05, 8'h03, OP_ADD, 1'b0);
        run_txn(8'hF0, 8'h0F, OP_NOR, 1'b0);
        run_txn(8'hFF, 8'h01, OP_ADD, 1'b0);

        // Second i_start during SEND_B must be ignored.
        fork
            run_txn(8'h81, 8'h02, OP_SRA, 1'b0);
            begin
                repeat (FRAME + FRAME / 2) @(negedge clk);
                pulse_start(8'hAA, 8'h55, OP_XOR);
            end
        join

        // Reset in the middle of SEND_B.
        pulse_start(8'h12, 8'h34, OP_XOR);
        exp_tx.push_back(8'h12); exp_tx.push_back(8'h34); exp_tx.push_back(OP_XOR);
        repeat (FRAME + 3 * BIT) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_tx", 32'(tx), 32'd1);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        exp_tx.delete();
        exp_res.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        run_txn(8'h0A, 8'h0B, OP_SUB, 1'b0);

        run_txn(8'h1E, 8'h1E, OP_ADD, 1'b1);

`ifdef ALU_HOST_TIMEOUT_EN
        begin
            int d0, f0, lat, lo, hi;
            d0 = done_count; f0 = ferr_count;
            exp_tx.push_back(8'h07); exp_tx.push_back(8'h09); exp_tx.push_back(OP_AND);
            exp_res.push_back({1'b1, 8'h00});
            fork
                pulse_start(8'h07, 8'h09, OP_AND);
                begin
                    repeat (4) @(negedge clk);
                    send_rx(8'h11, 1'b1);
                end
            join
            wait_frames();
            for (int k = 0; k < TO * L + 2 * FRAME && done_count == d0; k++) @(negedge clk);
            repeat (4) @(negedge clk);
            check_eq("to_done_pulses", done_count - d0, 1);
            check_eq("to_no_frame_err", ferr_count - f0, 0);
            lat = done_cyc - last_fall;
            lo  = FRAME - L + TO * L + 1;
            hi  = FRAME - 1 + TO * L + 1;
            $display("timeout latency from opcode start bit = %0d cycles (window %0d..%0d)", lat, lo, hi);
            check_eq("to_latency_in_window", 32'(lat >= lo && lat <= hi), 32'd1);
        end
`endif

        check_eq("scoreboard_tx_empty", exp_tx.size(), 0);
        check_eq("scoreboard_res_empty", exp_res.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #(3_000_000);
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
